// File: rtl/flag_window_counter_if.sv
// Bundles the detector-side input and the windowed report outputs of flag_window_counter.
interface flag_window_counter_if #(
    parameter int CNT_W = 8
);
    // No backpressure: cnt_valid is a single-cycle strobe and the consumer must take
    // cnt_out/sat in that cycle (they stay held until the next report anyway).
    logic             enable;
    logic             flag_in;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             sat;
    logic             busy;
    logic             dbg_state;

    modport master (
        output enable, flag_in,
        input  cnt_out, cnt_valid, sat, busy, dbg_state
    );

    modport slave (
        input  enable, flag_in,
        output cnt_out, cnt_valid, sat, busy, dbg_state
    );
endinterface

// File: rtl/flag_window_counter.sv
// Counts flag_in hits over back-to-back windows of WIN_LEN cycles and reports a
// saturating count with a one-cycle strobe at the end of each window.
module flag_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flag_window_counter_if.slave bus
);
    localparam int IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] acc_inc;

    // Accumulator plus this edge's sample, clamped so it never wraps.
    always_comb begin
        acc_inc = acc_q;
        if (bus.flag_in && (acc_q != CNT_MAX)) begin
            acc_inc = acc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            cnt_out_q <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            cnt_out_q <= cnt_out_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cnt_out_d = cnt_out_q;
        sat_d     = sat_q;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_COUNT;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_COUNT: begin
                // Dropping enable wins over a coincident last sample: the partial window is discarded.
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    acc_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    cnt_out_d = acc_inc;
                    sat_d     = (acc_inc == CNT_MAX);
                    valid_d   = 1'b1;
                    acc_d     = '0;
                    idx_d     = '0;
                end else begin
                    acc_d = acc_inc;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cnt_out   = cnt_out_q;
    assign bus.cnt_valid = valid_q;
    assign bus.sat       = sat_q;
    assign bus.busy      = (state_q == ST_COUNT);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_flag_window_counter.sv
// Runs three configurations of flag_window_counter on shared stimulus and compares each
// against a window-sum reference model every cycle, plus directed scenario checks.
module tb_flag_window_counter;
    localparam int NCFG = 3;
    localparam int WL_TAB [NCFG] = '{16, 16, 1};
    localparam int CW_TAB [NCFG] = '{8, 3, 1};

    bit   clk;
    logic rst_n;
    logic enable;
    logic flag_in;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int win_sum(input bit s[16], input int n);
        int acc = 0;
        for (int i = 0; i < n; i++) acc += int'(s[i]);
        return acc;
    endfunction

    function automatic int clamp(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int WL   = WL_TAB[g];
        localparam int CW   = CW_TAB[g];
        localparam int MAXV = (1 << CW) - 1;

        flag_window_counter_if #(.CNT_W(CW)) bus ();

        flag_window_counter #(.WIN_LEN(WL), .CNT_W(CW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.enable  = enable;
        assign bus.flag_in = flag_in;

        // Reference: record the samples of the current window, report their clamped sum.
        bit m_active;
        int m_n;
        bit m_samp [16];
        int m_out;
        bit m_valid;
        bit m_sat;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_active <= 1'b0;
                m_n      <= 0;
                m_out    <= 0;
                m_valid  <= 1'b0;
                m_sat    <= 1'b0;
            end else begin
                m_valid <= 1'b0;
                if (!m_active) begin
                    if (enable) begin
                        m_active <= 1'b1;
                        m_n      <= 0;
                    end
                end else if (!enable) begin
                    m_active <= 1'b0;
                    m_n      <= 0;
                end else if (m_n == WL - 1) begin
                    m_out   <= clamp(win_sum(m_samp, m_n) + int'(flag_in), MAXV);
                    m_sat   <= (win_sum(m_samp, m_n) + int'(flag_in)) >= MAXV;
                    m_valid <= 1'b1;
                    m_n     <= 0;
                end else begin
                    m_samp[m_n] <= flag_in;
                    m_n         <= m_n + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n !== 1'bx) begin
                check_eq($sformatf("c%0d_valid", g), 32'(bus.cnt_valid), 32'(m_valid));
                check_eq($sformatf("c%0d_cnt", g),   32'(bus.cnt_out),   32'(m_out));
                check_eq($sformatf("c%0d_sat", g),   32'(bus.sat),       32'(m_sat));
                check_eq($sformatf("c%0d_busy", g),  32'(bus.busy),      32'(m_active));
            end
        end
    end

    task automatic step(input bit en, input bit fl);
        enable  = en;
        flag_in = fl;
        @(negedge clk);
    endtask

    // pat[k-1] is the flag value for sample k of a window already in progress.
    task automatic run_window(input logic [15:0] pat);
        for (int k = 0; k < 16; k++) step(1'b1, pat[k]);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_c0_cnt"},  32'(g_cfg[0].bus.cnt_out),   32'd0);
        check_eq({tag, "_c0_val"},  32'(g_cfg[0].bus.cnt_valid), 32'd0);
        check_eq({tag, "_c0_sat"},  32'(g_cfg[0].bus.sat),       32'd0);
        check_eq({tag, "_c0_busy"}, 32'(g_cfg[0].bus.busy),      32'd0);
        check_eq({tag, "_c1_cnt"},  32'(g_cfg[1].bus.cnt_out),   32'd0);
        check_eq({tag, "_c1_busy"}, 32'(g_cfg[1].bus.busy),      32'd0);
        check_eq({tag, "_c2_cnt"},  32'(g_cfg[2].bus.cnt_out),   32'd0);
        check_eq({tag, "_c2_busy"}, 32'(g_cfg[2].bus.busy),      32'd0);
    endtask

    initial begin
        bit fl;
        rst_n   = 1'b0;
        enable  = 1'b1;
        flag_in = 1'b0;
        #15 flag_in = 1'b1;
        #5  flag_in = 1'b0;
        #1  check_all_zero("rst_hold");
        #1  rst_n  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0);

        // Hits on samples 2, 9 and 16.
        step(1'b1, 1'b0);
        run_window(16'h8102);
        check_eq("basic_valid", 32'(g_cfg[0].bus.cnt_valid), 32'd1);
        check_eq("basic_cnt",   32'(g_cfg[0].bus.cnt_out),   32'd3);
        check_eq("basic_sat",   32'(g_cfg[0].bus.sat),       32'd0);

        // Full window of hits saturates the 3-bit configuration.
        run_window(16'hFFFF);
        check_eq("full_c0_cnt", 32'(g_cfg[0].bus.cnt_out), 32'd16);
        check_eq("full_c0_sat", 32'(g_cfg[0].bus.sat),     32'd0);
        check_eq("sat_c1_cnt",  32'(g_cfg[1].bus.cnt_out), 32'd7);
        check_eq("sat_c1_sat",  32'(g_cfg[1].bus.sat),     32'd1);
        run_window(16'h0024);
        check_eq("after_c1_cnt", 32'(g_cfg[1].bus.cnt_out), 32'd2);
        check_eq("after_c1_sat", 32'(g_cfg[1].bus.sat),     32'd0);

        // Abort at sample 10 after 5 hits.
        for (int k = 0; k < 9; k++) step(1'b1, (k % 2) == 0);
        step(1'b0, 1'b1);
        check_eq("abort_valid", 32'(g_cfg[0].bus.cnt_valid), 32'd0);
        check_eq("abort_busy",  32'(g_cfg[0].bus.busy),      32'd0);
        check_eq("abort_cnt",   32'(g_cfg[0].bus.cnt_out),   32'd2);
        step(1'b1, 1'b0);
        run_window(16'h0100);
        check_eq("reen_cnt", 32'(g_cfg[0].bus.cnt_out), 32'd1);

        // Enable dropped exactly on the last sample.
        for (int k = 0; k < 15; k++) step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1);
        check_eq("abl_valid", 32'(g_cfg[0].bus.cnt_valid), 32'd0);
        check_eq("abl_busy",  32'(g_cfg[0].bus.busy),      32'd0);
        check_eq("abl_cnt",   32'(g_cfg[0].bus.cnt_out),   32'd1);
        step(1'b0, 1'b0);

        // Asynchronous reset in the middle of a window.
        step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        #5 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        #8 rst_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0);
        check_eq("rst_idle_busy", 32'(g_cfg[0].bus.busy),      32'd0);
        check_eq("rst_no_report", 32'(g_cfg[0].bus.cnt_valid), 32'd0);

        // WIN_LEN = 1: every sampling edge reports the sampled bit.
        step(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            fl = 1'($urandom_range(0, 1));
            step(1'b1, fl);
            check_eq("w1_valid", 32'(g_cfg[2].bus.cnt_valid), 32'd1);
            check_eq("w1_cnt",   32'(g_cfg[2].bus.cnt_out),   32'(fl));
            check_eq("w1_sat",   32'(g_cfg[2].bus.sat),       32'(fl));
        end

        // Random enable/flag traffic, checked cycle by cycle against the models.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
